// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier datapath.
// Product width and the accumulator state encoding live here.
package booth_pkg;

  localparam int DEF_PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // Replicates bit w-1 into all higher bits of a 64-bit word.
  function automatic logic [63:0] sign_extend(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++) begin
      if (i >= int'(w)) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_product_accumulator.sv
// Dot-product stage: sums N_TERMS signed products per run.
// Valid/ready on both sides, sticky signed-overflow flag.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  acc_state_t       state, state_n;
  logic [ACC_W-1:0] acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf_n;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;
  logic             accept;

  assign ext = ACC_W'(sign_extend(64'(product), PROD_W));
  assign sum = acc_out + ext;

  // Same-sign operands whose result flips sign.
  assign sum_ovf = (acc_out[ACC_W-1] == ext[ACC_W-1])
                && (sum[ACC_W-1] != acc_out[ACC_W-1]);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc_out;
    cnt_n   = cnt;
    ovf_n   = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ACCUM;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = sum;
          cnt_n = cnt + 1'b1;
          ovf_n = overflow | sum_ovf;
          if (cnt == LAST) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_out  <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      acc_out  <= acc_n;
      cnt      <= cnt_n;
      overflow <= ovf_n;
    end
  end

endmodule
